// File: rtl/regfile_pkg.sv
// Shared register-file widths and the write-queue entry layout.
package regfile_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int NUM_REGS   = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] address;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;

   localparam int ENTRY_W = $bits(wb_entry_t);
endpackage

// File: rtl/wb_queue_lookup.sv
// Bypass match over the pending writes: youngest queued match wins, then the
// entry sitting in the output register; r0 never hits.
module wb_queue_lookup
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic [DEPTH*ENTRY_W-1:0] entries,      // oldest at slot 0
   input  logic [DEPTH-1:0]         entry_valid,
   input  logic                     out_valid,
   input  logic [REG_ADDR_W-1:0]    out_address,
   input  logic [DATA_W-1:0]        out_data,
   input  logic [REG_ADDR_W-1:0]    lookup_address,
   output logic                     lookup_hit,
   output logic [DATA_W-1:0]        lookup_data
);

   wb_entry_t cand;

   always_comb begin
      lookup_hit  = 1'b0;
      lookup_data = '0;
      cand        = '0;
      // Ascending age scan: a later (younger) match overwrites an older one.
      for (int i = 0; i < DEPTH; i++) begin
         cand = entries[i*ENTRY_W +: ENTRY_W];
         if (entry_valid[i] && cand.address == lookup_address) begin
            lookup_hit  = 1'b1;
            lookup_data = cand.data;
         end
      end
      if (!lookup_hit && out_valid && out_address == lookup_address) begin
         lookup_hit  = 1'b1;
         lookup_data = out_data;
      end
      if (lookup_address == '0) begin
         lookup_hit  = 1'b0;
         lookup_data = '0;
      end
   end

endmodule

// File: rtl/wb_write_queue.sv
// Register-file write-back queue: buffers producer writes, drains one per
// unstalled cycle into registered write-port outputs, and offers a bypass lookup.
module wb_write_queue
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                        clock,
   input  logic                        Reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [REG_ADDR_W-1:0]       in_address,
   input  logic [DATA_W-1:0]           in_data,
   input  logic                        port_stall,
   output logic                        reg_write_enable,
   output logic [REG_ADDR_W-1:0]       reg_write_address,
   output logic [DATA_W-1:0]           write_data,
   input  logic [REG_ADDR_W-1:0]       lookup_address,
   output logic                        lookup_hit,
   output logic [DATA_W-1:0]           lookup_data,
   output logic [$clog2(DEPTH):0]      pending_count,
   output logic                        empty,
   output logic                        full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_entry_t          mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               accept;
   logic               push;
   logic               pop;
   logic [DEPTH*ENTRY_W-1:0] aged_entries;
   logic [DEPTH-1:0]         aged_valid;

   assign empty         = (count == '0);
   assign full          = (count == CNT_W'(DEPTH));
   assign pending_count = count;

   // Readiness depends only on the registered count, so a full queue never
   // refills in the cycle it pops.
   assign in_ready = Reset || !full;
   assign accept   = in_valid && !full && !Reset;
   assign push     = accept && (in_address != '0);
   assign pop      = !empty && !port_stall;

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= '{address: in_address, data: in_data};
      end
   end

   always_ff @(posedge clock) begin
      if (Reset) begin
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         count             <= '0;
         reg_write_enable  <= 1'b0;
         reg_write_address <= '0;
         write_data        <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr            <= rd_ptr + 1'b1;
            reg_write_enable  <= 1'b1;
            reg_write_address <= mem[rd_ptr].address;
            write_data        <= mem[rd_ptr].data;
         end else begin
            reg_write_enable  <= 1'b0;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Present the live entries oldest-first so the lookup can rank by age.
   always_comb begin
      aged_entries = '0;
      aged_valid   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         aged_entries[i*ENTRY_W +: ENTRY_W] = mem[rd_ptr + PTR_W'(i)];
         aged_valid[i] = (CNT_W'(i) < count);
      end
   end

   wb_queue_lookup #(.DEPTH(DEPTH)) u_lookup (
      .entries        (aged_entries),
      .entry_valid    (aged_valid),
      .out_valid      (reg_write_enable),
      .out_address    (reg_write_address),
      .out_data       (write_data),
      .lookup_address (lookup_address),
      .lookup_hit     (lookup_hit),
      .lookup_data    (lookup_data)
   );

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: queue-based reference model compared every cycle,
// strobe scoreboard, directed scenarios with literal expectations, random run.
module tb_wb_write_queue;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   logic        clock;
   logic        Reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_address;
   logic [31:0] in_data;
   logic        port_stall;
   logic        reg_write_enable;
   logic [4:0]  reg_write_address;
   logic [31:0] write_data;
   logic [4:0]  lookup_address;
   logic        lookup_hit;
   logic [31:0] lookup_data;
   logic [2:0]  pending_count;
   logic        empty;
   logic        full;

   wb_write_queue #(.DEPTH(DEPTH)) dut (
      .clock             (clock),
      .Reset             (Reset),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_address        (in_address),
      .in_data           (in_data),
      .port_stall        (port_stall),
      .reg_write_enable  (reg_write_enable),
      .reg_write_address (reg_write_address),
      .write_data        (write_data),
      .lookup_address    (lookup_address),
      .lookup_hit        (lookup_hit),
      .lookup_data       (lookup_data),
      .pending_count     (pending_count),
      .empty             (empty),
      .full              (full)
   );

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- counters and check ----------------
   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   ent_t        m_q[$];
   logic        m_we = 1'b0;
   logic [4:0]  m_wa = '0;
   logic [31:0] m_wd = '0;
   int          m_pushes = 0;
   logic [36:0] exp_q[$];

   always @(posedge clock) begin
      bit was_full;
      was_full = (m_q.size() == DEPTH);
      if (Reset) begin
         m_q.delete();
         exp_q.delete();
         m_we = 1'b0;
         m_wa = '0;
         m_wd = '0;
      end else begin
         if (m_q.size() > 0 && !port_stall) begin
            m_we = 1'b1;
            m_wa = m_q[0].a;
            m_wd = m_q[0].d;
            void'(m_q.pop_front());
         end else begin
            m_we = 1'b0;
         end
         if (in_valid && !was_full && in_address != 5'd0) begin
            m_q.push_back('{a: in_address, d: in_data});
            exp_q.push_back({in_address, in_data});
            m_pushes++;
         end
      end
   end

   function automatic logic [32:0] m_lookup(input logic [4:0] a);
      if (a == 5'd0) return '0;
      for (int i = m_q.size() - 1; i >= 0; i--)
         if (m_q[i].a == a) return {1'b1, m_q[i].d};
      if (m_we && m_wa == a) return {1'b1, m_wd};
      return '0;
   endfunction

   // ---------------- per-cycle compare ----------------
   always @(negedge clock) begin
      if (chk_en) begin
         logic [32:0] lk;
         lk = m_lookup(lookup_address);
         check("in_ready", 64'(in_ready), 64'(Reset || m_q.size() < DEPTH));
         check("pending_count", 64'(pending_count), 64'(m_q.size()));
         check("empty", 64'(empty), 64'(m_q.size() == 0));
         check("full", 64'(full), 64'(m_q.size() == DEPTH));
         check("reg_write_enable", 64'(reg_write_enable), 64'(m_we));
         check("reg_write_address", 64'(reg_write_address), 64'(m_wa));
         check("write_data", 64'(write_data), 64'(m_wd));
         check("lookup_hit", 64'(lookup_hit), 64'(lk[32]));
         check("lookup_data", 64'(lookup_data), 64'(lk[31:0]));
         if (reg_write_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("strobe_unexpected", 64'(reg_write_address), 64'h1_0000_0000);
            end else begin
               check("strobe_order", 64'({reg_write_address, write_data}), 64'(exp_q[0]));
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [4:0] a, input logic [31:0] d);
      in_valid   = 1'b1;
      in_address = a;
      in_data    = d;
      tick();
      in_valid   = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      Reset          = 1'b1;
      in_valid       = 1'b0;
      in_address     = '0;
      in_data        = '0;
      port_stall     = 1'b0;
      lookup_address = '0;
      tick();
      chk_en = 1'b1;

      // Requests during reset are ignored; in_ready reads 1.
      in_valid = 1'b1; in_address = 5'd3; in_data = 32'h5555_5555;
      @(negedge clock);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_count", 64'(pending_count), 64'd0);
      check("rst_we", 64'(reg_write_enable), 64'd0);
      tick();
      in_valid = 1'b0;
      Reset    = 1'b0;

      // Single write latency.
      push(5'd1, 32'hABCD_EF12);
      @(negedge clock);
      check("lat_we_early", 64'(reg_write_enable), 64'd0);
      check("lat_count", 64'(pending_count), 64'd1);
      tick();
      @(negedge clock);
      check("lat_we", 64'(reg_write_enable), 64'd1);
      check("lat_addr", 64'(reg_write_address), 64'd1);
      check("lat_data", 64'(write_data), 64'hABCD_EF12);
      tick();
      @(negedge clock);
      check("lat_we_once", 64'(reg_write_enable), 64'd0);

      // r0 writes are discarded.
      lookup_address = 5'd0;
      push(5'd0, 32'hFFFF_FFFF);
      @(negedge clock);
      check("r0_count", 64'(pending_count), 64'd0);
      check("r0_hit", 64'(lookup_hit), 64'd0);
      tick();
      @(negedge clock);
      check("r0_we", 64'(reg_write_enable), 64'd0);

      // Fill under stall, then drain back-to-back.
      port_stall = 1'b1;
      for (int a = 2; a <= 5; a++) push(5'(a), 32'h100 + 32'(a));
      @(negedge clock);
      check("fill_full", 64'(full), 64'd1);
      check("fill_ready", 64'(in_ready), 64'd0);
      port_stall = 1'b0;
      for (int a = 2; a <= 5; a++) begin
         tick();
         @(negedge clock);
         check("drain_we", 64'(reg_write_enable), 64'd1);
         check("drain_addr", 64'(reg_write_address), 64'(a));
      end
      tick();

      // Duplicate address: youngest wins on lookup, both still issue in order.
      port_stall = 1'b1;
      push(5'd7, 32'h11);
      push(5'd7, 32'h22);
      lookup_address = 5'd7;
      @(negedge clock);
      check("dup_hit", 64'(lookup_hit), 64'd1);
      check("dup_data", 64'(lookup_data), 64'h22);
      port_stall = 1'b0;
      tick();
      @(negedge clock);
      check("dup_first", 64'(write_data), 64'h11);
      tick();
      @(negedge clock);
      check("dup_second", 64'(write_data), 64'h22);
      tick();
      @(negedge clock);
      check("dup_nohit", 64'(lookup_hit), 64'd0);

      // Reset mid-operation.
      port_stall = 1'b1;
      push(5'd8, 32'h8);
      push(5'd9, 32'h9);
      push(5'd10, 32'hA);
      Reset = 1'b1;
      tick();
      Reset      = 1'b0;
      port_stall = 1'b0;
      @(negedge clock);
      check("mid_rst_count", 64'(pending_count), 64'd0);
      check("mid_rst_we", 64'(reg_write_enable), 64'd0);
      for (int a = 0; a < 32; a++) begin
         lookup_address = 5'(a);
         tick();
         @(negedge clock);
         check("mid_rst_hit", 64'(lookup_hit), 64'd0);
      end

      // Random traffic.
      m_pushes = 0;
      for (int c = 0; c < 1000; c++) begin
         in_valid       = ($urandom_range(0, 9) < 7);
         in_address     = 5'($urandom_range(0, 31));
         in_data        = $urandom;
         port_stall     = ($urandom_range(0, 3) == 0);
         lookup_address = (c % 2 == 0) ? in_address : 5'($urandom_range(0, 31));
         tick();
      end
      in_valid   = 1'b0;
      port_stall = 1'b0;
      repeat (DEPTH + 3) tick();
      @(negedge clock);
      check("wraps_ge_50", 64'(m_pushes / DEPTH >= 50), 64'd1);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      check("final_empty", 64'(empty), 64'd1);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_write_queue.md
WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 DEPTH, default 4, number of queued write entries; SHALL be a power of two and at least 2.
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Reset  input  1  SHALL be synchronous and active-high.
REQ-004 in_valid  input  1  producer write request.
REQ-005 in_ready  output  1  queue can accept a request.
REQ-006 in_address  input  5  destination register.
REQ-007 in_data  input  32  write value.
REQ-008 port_stall  input  1  register-file write port unavailable this cycle.
REQ-009 reg_write_enable  output  1  register-file write strobe, registered.
REQ-010 reg_write_address  output  5  register-file write address, registered.
REQ-011 write_data  output  32  register-file write data, registered.
REQ-012 lookup_address  input  5  bypass query address.
REQ-013 lookup_hit  output  1  a pending write to lookup_address exists, combinational.
REQ-014 lookup_data  output  32  newest pending value for lookup_address; 0 when no hit.
REQ-015 pending_count  output  $clog2(DEPTH)+1  number of queued entries.
REQ-016 empty / full  output  1 each  pending_count==0 / pending_count==DEPTH.

Function
REQ-017 Accept: the queue SHALL accept a request on an edge where in_valid && in_ready; in_ready SHALL equal !full.
REQ-018 Full: when full, in_ready SHALL be 0 even if a pop occurs in the same cycle; there is no same-cycle refill.
REQ-019 r0: an accepted request with in_address==0 SHALL be consumed and discarded, with no entry, no count change and no strobe.
REQ-020 Drain: on each edge where !empty && !port_stall, the head entry SHALL be popped and loaded into the output registers with reg_write_enable<=1.
REQ-021 Idle output: on an edge with empty || port_stall, reg_write_enable SHALL be set to 0; reg_write_address and write_data SHALL hold their values.
REQ-022 Latency: a request accepted at edge k into an empty, unstalled queue SHALL produce reg_write_enable=1 during the cycle after edge k+1, so it commits at edge k+2.
REQ-023 Throughput: with no stall, the queue SHALL issue one strobe per cycle back-to-back.
REQ-024 Order: entries SHALL be issued in strict FIFO order; duplicate addresses SHALL NOT be coalesced.
REQ-025 Simultaneous push and pop: pending_count SHALL be unchanged.
REQ-026 Pointers: read and write pointers SHALL wrap modulo DEPTH.
REQ-027 Lookup priority: the youngest queued entry matching lookup_address SHALL win.
REQ-028 Lookup fallback: if no queued entry matches, the output-register entry SHALL be the hit when reg_write_enable=1 and reg_write_address==lookup_address.
REQ-029 Lookup r0: lookup_address==0 SHALL always give lookup_hit=0.
REQ-030 Stall timing: port_stall SHALL be sampled at the edge only; deasserting it SHALL resume drain at the next edge without losing or repeating an entry.

Reset
REQ-031 On an edge with Reset=1, the queue SHALL clear pointers and count, and set reg_write_enable, reg_write_address and write_data to 0.
REQ-032 During Reset, in_ready SHALL read 1 and requests presented SHALL be ignored.
REQ-033 Reset mid-operation SHALL discard all pending entries; no strobe SHALL occur in the cycle after the reset edge.

Structure
REQ-034 Package regfile_pkg SHALL hold REG_ADDR_W=5, DATA_W=32, NUM_REGS=32 and a packed struct wb_entry_t {address, data}.
REQ-035 The combinational priority match SHALL be one sub-module, wb_queue_lookup; storage and pointers SHALL stay in wb_write_queue.

Verification
REQ-036 Reset, then write r1=0xABCDEF12 at edge k -> reg_write_enable=1, reg_write_address=1, write_data=0xABCDEF12 in the cycle after edge k+1 only.
REQ-037 Push r0=0xFFFFFFFF -> pending_count stays 0, no strobe, and lookup r0 gives hit=0.
REQ-038 Hold port_stall=1 and push r2..r5 -> full=1, in_ready=0; then release stall -> four strobes r2,r3,r4,r5 on consecutive cycles.
REQ-039 Push r7=0x11 then r7=0x22 with stall held, lookup r7 -> hit=1, data=0x22; after draining -> two strobes, 0x11 then 0x22.
REQ-040 Queue 3 entries, assert Reset for one edge -> count=0, reg_write_enable=0 next cycle, lookup_hit=0 for all addresses.
REQ-041 Run 10 random back-to-back pushes and pops for 1000 cycles against a scoreboard -> strobes match in order, and pointer wrap is exercised at least 50 times.
